expr_stream_checker: RTL
========================

# expr_stream_checker

Parametrised streaming validator for arithmetic expression strings. It accepts one ASCII character per handshake cycle and reports, after every accepted character, whether the prefix seen so far is a complete, well-formed expression. It supports multi-digit numbers, `+ - *`, and nested parentheses. It sits after the character source in the input-checking path and supersedes the single-digit `+`/`*` checker.

## Interface
Parameters:
- MAX_DEPTH, 4: maximum parenthesis nesting depth (≥1)
- MAX_DIGITS, 3: maximum digits per number literal (≥1)
- CNT_W, 8: width of number-literal counter
- DEPTH_W, $clog2(MAX_DEPTH+1): width of depth output (derived)

Ports (reset clr, asynchronous, active-high; clock clk):
- clk  in  1  clock, rising edge
- clr  in  1  asynchronous active-high reset
- in_valid  in  1  character on `in` is consumed at this edge
- in  in  8  ASCII character
- out  out  1  prefix is a complete valid expression
- err  out  1  sticky error flag
- err_code  out  2  00 none, 01 syntax/illegal char, 10 unbalanced ')', 11 limit exceeded
- depth  out  DEPTH_W  current open-parenthesis count
- num_count  out  CNT_W  number literals started since reset (saturating)

## Operation
- Character classes:
  - DIGIT: '0'–'9'
  - OP: '+' '-' '*'
  - LP: '('
  - RP: ')'
  - anything else: ILLEGAL
- Internal state: 2-bit FSM {S_EXP, S_NUM, S_CLS, S_ERR}, depth counter, digit counter (width to hold MAX_DIGITS), num_count.
- S_EXP (expecting operand; reset state):
  - DIGIT → S_NUM, digit_cnt=1, num_count+1.
  - LP → depth==MAX_DEPTH ? S_ERR/11 : depth+1, stay.
  - OP, RP, ILLEGAL → S_ERR/01.
- S_NUM:
  - DIGIT → digit_cnt==MAX_DIGITS ? S_ERR/11 : digit_cnt+1.
  - OP → S_EXP.
  - RP → depth==0 ? S_ERR/10 : depth−1, S_CLS.
  - LP, ILLEGAL → S_ERR/01.
- S_CLS (after ')'):
  - OP → S_EXP.
  - RP → depth==0 ? S_ERR/10 : depth−1, stay.
  - DIGIT, LP, ILLEGAL → S_ERR/01.
- S_ERR: absorbing. All inputs are ignored until clr. depth, num_count and err_code freeze at their values from the failing cycle; err_code is written exactly once.
- out = (state==S_NUM or S_CLS) and depth==0. out is combinational from registers only; it never depends on `in` directly.
- err = (state==S_ERR).
- Leading zeros are legal and count toward MAX_DIGITS. Unary minus is illegal ("-1" → 01). Empty parentheses "()" → 01.
- num_count saturates at 2^CNT_W−1; it does not wrap.
- in_valid=0: no register changes, regardless of `in`.

## Timing
- Reset values (clr high, immediately, no clock needed):
  - state=S_EXP, depth=0, digit_cnt=0, num_count=0
  - out=0, err=0, err_code=00
- clr dominates clk and in_valid. A character presented on the edge where clr deasserts is not consumed if clr is still high at that edge.
- Latency: a character accepted at edge N is reflected on all outputs after edge N, i.e. valid in cycle N+1.
- Throughput: one character per cycle; no backpressure (no ready signal).
- Limit checks use pre-update values: the (MAX_DEPTH+1)th consecutive LP and the (MAX_DIGITS+1)th digit fail. The MAX_DEPTH-th LP and the MAX_DIGITS-th digit are accepted.

## Test plan
- "12+3", in_valid=1 every cycle → out after each char 1,1,0,1. num_count=2, err=0.
- MAX_DEPTH=4, "(1+(2*3))" → depth trace 1,1,1,2,2,2,2,1,0. out=1 only after final ')'. err=0.
- "1)" → after ')': err=1, err_code=10, out=0, depth=0. Subsequent "+5" leaves all outputs unchanged.
- MAX_DIGITS=3, "1234" → after '3': out=1. After '4': err=1, err_code=11. MAX_DEPTH=4, "(((((" → err_code=11 on 5th '(', depth=4.
- "7", then 3 cycles in_valid=0 with in='x', then "+", "2" → idle cycles change nothing (out stays 1). Final out=1, num_count=2. Separately, "a" → err_code=01.
- "(1+" then clr pulse mid-cycle (asynchronous) → outputs zero before next edge. Then "9" → out=1, num_count=1, depth=0.

Source files
------------

// File: rtl/expr_stream_checker.sv
// rtl/expr_stream_checker.sv - streaming validator for multi-digit +,-,* expressions with nested parentheses
module expr_stream_checker #(
  parameter int MAX_DEPTH  = 4,
  parameter int MAX_DIGITS = 3,
  parameter int CNT_W      = 8,
  parameter int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   num_count
);

  // Digit counter only has to reach MAX_DIGITS; the overflowing digit is rejected before it is counted.
  localparam int DIG_W = $clog2(MAX_DIGITS + 1);

  localparam logic [DEPTH_W-1:0] DEPTH_LIM = DEPTH_W'(MAX_DEPTH);
  localparam logic [DIG_W-1:0]   DIG_LIM   = DIG_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]   CNT_SAT   = {CNT_W{1'b1}};

  localparam logic [1:0] E_NONE   = 2'b00;
  localparam logic [1:0] E_SYNTAX = 2'b01;
  localparam logic [1:0] E_UNBAL  = 2'b10;
  localparam logic [1:0] E_LIMIT  = 2'b11;

  // S_EXP: waiting for an operand, S_NUM: inside a literal, S_CLS: just after ')', S_ERR: absorbing.
  typedef enum logic [1:0] {
    S_EXP = 2'd0,
    S_NUM = 2'd1,
    S_CLS = 2'd2,
    S_ERR = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_DIGIT = 3'd0,
    C_OP    = 3'd1,
    C_LP    = 3'd2,
    C_RP    = 3'd3,
    C_ILL   = 3'd4
  } cls_t;

  state_t             state, state_nxt;
  cls_t               cls;
  logic [DEPTH_W-1:0] depth_nxt;
  logic [DIG_W-1:0]   digit_cnt, digit_cnt_nxt;
  logic [CNT_W-1:0]   num_count_nxt;
  logic [1:0]         err_code_nxt;

  // Classify the incoming ASCII character.
  always_comb begin
    cls = C_ILL;
    if (in >= 8'h30 && in <= 8'h39) begin
      cls = C_DIGIT;
    end else begin
      case (in)
        8'h2B, 8'h2D, 8'h2A: cls = C_OP;
        8'h28:               cls = C_LP;
        8'h29:               cls = C_RP;
        default:             cls = C_ILL;
      endcase
    end
  end

  // State and counter registers; clr clears everything without waiting for a clock.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_EXP;
      depth     <= '0;
      digit_cnt <= '0;
      num_count <= '0;
      err_code  <= E_NONE;
    end else begin
      state     <= state_nxt;
      depth     <= depth_nxt;
      digit_cnt <= digit_cnt_nxt;
      num_count <= num_count_nxt;
      err_code  <= err_code_nxt;
    end
  end

  // Next-state rules; a failing character moves to S_ERR and leaves depth/num_count untouched.
  always_comb begin
    state_nxt     = state;
    depth_nxt     = depth;
    digit_cnt_nxt = digit_cnt;
    num_count_nxt = num_count;
    err_code_nxt  = err_code;
    if (in_valid) begin
      case (state)
        S_EXP: begin
          case (cls)
            C_DIGIT: begin
              state_nxt     = S_NUM;
              digit_cnt_nxt = DIG_W'(1);
              if (num_count != CNT_SAT) num_count_nxt = num_count + CNT_W'(1);
            end
            C_LP: begin
              if (depth == DEPTH_LIM) begin
                state_nxt    = S_ERR;
                err_code_nxt = E_LIMIT;
              end else begin
                depth_nxt = depth + DEPTH_W'(1);
              end
            end
            default: begin
              state_nxt    = S_ERR;
              err_code_nxt = E_SYNTAX;
            end
          endcase
        end
        S_NUM: begin
          case (cls)
            C_DIGIT: begin
              if (digit_cnt == DIG_LIM) begin
                state_nxt    = S_ERR;
                err_code_nxt = E_LIMIT;
              end else begin
                digit_cnt_nxt = digit_cnt + DIG_W'(1);
              end
            end
            C_OP: begin
              state_nxt     = S_EXP;
              digit_cnt_nxt = '0;
            end
            C_RP: begin
              if (depth == '0) begin
                state_nxt    = S_ERR;
                err_code_nxt = E_UNBAL;
              end else begin
                state_nxt     = S_CLS;
                depth_nxt     = depth - DEPTH_W'(1);
                digit_cnt_nxt = '0;
              end
            end
            default: begin
              state_nxt    = S_ERR;
              err_code_nxt = E_SYNTAX;
            end
          endcase
        end
        S_CLS: begin
          case (cls)
            C_OP: begin
              state_nxt = S_EXP;
            end
            C_RP: begin
              if (depth == '0) begin
                state_nxt    = S_ERR;
                err_code_nxt = E_UNBAL;
              end else begin
                depth_nxt = depth - DEPTH_W'(1);
              end
            end
            default: begin
              state_nxt    = S_ERR;
              err_code_nxt = E_SYNTAX;
            end
          endcase
        end
        default: begin
          state_nxt = S_ERR;
        end
      endcase
    end
  end

  // Outputs come from registers only, so they never see the current input character.
  always_comb begin
    out = ((state == S_NUM) || (state == S_CLS)) && (depth == '0);
    err = (state == S_ERR);
  end

endmodule
